// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths, control-field layout and skid-buffer state encoding for the
// decode/execute pipeline register.
package pipe_stage_reg_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;
  localparam int DATA_DEF_W = 3 * REG_ADDR_W + 3 * WORD_W;
  localparam int CNT_DEF_W  = 16;

  // Declared MSB first: alu_src lands at bit 0 and reg_write at bit 7.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_dst;
    logic [2:0] alu_op;
    logic       alu_src;
  } ctrl_t;

  localparam int CTRL_DEF_W = $bits(ctrl_t);

  typedef logic [1:0] state_t;
  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of the pipeline register.
// The master side drives the entries; the slave side is the stage itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W = pipe_stage_reg_pkg::DATA_DEF_W,
  parameter int CTRL_W = pipe_stage_reg_pkg::CTRL_DEF_W,
  parameter int CNT_W  = pipe_stage_reg_pkg::CNT_DEF_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              bubble;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output in_valid, in_data, in_ctrl, bubble, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, bubble_cnt
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, bubble, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, bubble_cnt
  );

endinterface

// File: rtl/pipe_slot.sv
// One entry of the skid buffer: enable-loaded payload+control register that
// clears asynchronously on reset.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register with bubble/flush control and a
// saturating count of cycles where downstream was ready but starved.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = DATA_DEF_W,
  parameter int CTRL_W = CTRL_DEF_W,
  parameter int CNT_W  = CNT_DEF_W
) (
  input  logic            clk,
  input  logic            reset_n,
  pipe_stage_reg_if.slave bus
);

  localparam int SLOT_W = DATA_W + CTRL_W;

  // EMPTY: nothing held | ONE: main holds head | FULL: main head, skid next
  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [SLOT_W-1:0] w_main_q;
  logic [SLOT_W-1:0] w_skid_q;
  logic [SLOT_W-1:0] w_main_d;
  logic [SLOT_W-1:0] w_skid_d;
  logic [SLOT_W-1:0] w_in_slot;
  logic              w_main_en;
  logic              w_skid_en;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_pop;

  assign w_in_ready  = (r_state != ST_FULL) & ~bus.bubble & ~bus.flush;
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready & ~bus.flush;
  assign w_in_slot   = {bus.in_data, bus.in_ctrl};

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_accept && !w_pop)      w_state_nxt = ST_FULL;
          else if (!w_accept && w_pop) w_state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Flush loads zero into both slots so no stale control survives.
  assign w_main_en = bus.flush
                   | (w_accept & ((r_state == ST_EMPTY) | w_pop))
                   | ((r_state == ST_FULL) & w_pop);
  assign w_main_d  = bus.flush ? '0
                   : (r_state == ST_FULL) ? w_skid_q : w_in_slot;
  assign w_skid_en = bus.flush | ((r_state == ST_ONE) & w_accept & ~w_pop);
  assign w_skid_d  = bus.flush ? '0 : w_in_slot;

  pipe_slot #(.W(SLOT_W)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_main_en),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  pipe_slot #(.W(SLOT_W)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_skid_en),
    .i_d     (w_skid_d),
    .o_q     (w_skid_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bubble_cnt <= '0;
    end else if (!w_out_valid && bus.out_ready && !(&r_bubble_cnt)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_main_q[SLOT_W-1 -: DATA_W];
  assign bus.out_ctrl   = w_out_valid ? w_main_q[CTRL_W-1:0] : '0;
  assign bus.bubble_cnt = r_bubble_cnt;

endmodule
